dice_router_cfg_loader: RTL and testbench

Configuration front-end for the 2×32 CGRA tile router: accepts a 32-bit configuration word stream over a valid/ready handshake, assembles the router's static per-output fields into a shadow register, and transfers them to an active register on an explicit commit. Sits directly upstream of the router and drives its `sel_*`, `overload_en_*` and `registered_mode_*` inputs. Runtime `overload_ctrl_*` is not handled here.

---
 rtl/dice_router_cfg_pkg.sv | 30 +++
 rtl/dice_router_cfg_loader.sv | 124 ++++++++++++
 tb/tb_dice_router_cfg_loader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/dice_router_cfg_pkg.sv
// Shared constants and types for the router configuration loader.
package dice_router_cfg_pkg;

  localparam int unsigned NUM_PORTS = 12;
  localparam int unsigned SEL_W     = 4;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned CFG_BITS  = NUM_PORTS * (SEL_W + 2);
  localparam int unsigned NUM_WORDS = (CFG_BITS + WORD_W - 1) / WORD_W;

  // Shadow field offsets: sel fields occupy [OVL_BASE-1:0].
  localparam int unsigned OVL_BASE = NUM_PORTS * SEL_W;
  localparam int unsigned REG_BASE = OVL_BASE + NUM_PORTS;

  // Router output indices.
  localparam int unsigned PORT_N_T0 = 0;
  localparam int unsigned PORT_N_T1 = 1;
  localparam int unsigned PORT_E_T0 = 2;
  localparam int unsigned PORT_E_T1 = 3;
  localparam int unsigned PORT_S_T0 = 4;
  localparam int unsigned PORT_S_T1 = 5;
  localparam int unsigned PORT_W_T0 = 6;
  localparam int unsigned PORT_W_T1 = 7;
  localparam int unsigned PORT_L_T0 = 8;
  localparam int unsigned PORT_L_T1 = 9;
  localparam int unsigned PORT_L_T2 = 10;
  localparam int unsigned PORT_L_T3 = 11;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, FULL} cfg_state_e;

endpackage

// File: rtl/dice_router_cfg_loader.sv
// Assembles a 3-word configuration frame into a shadow register and copies it
// to the active router configuration on commit.
module dice_router_cfg_loader
  import dice_router_cfg_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [WORD_W-1:0]          cfg_data,
  input  logic                       cfg_last,
  input  logic                       commit,
  output logic                       cfg_loaded,
  output logic                       cfg_err,
  output logic [NUM_PORTS*SEL_W-1:0] sel_o,
  output logic [NUM_PORTS-1:0]       overload_en_o,
  output logic [NUM_PORTS-1:0]       registered_mode_o
);

  localparam logic [1:0] LAST_WORD = 2'(NUM_WORDS - 1);
  localparam int unsigned TAIL_W = CFG_BITS - 2 * WORD_W;

  cfg_state_e                 state_q, state_d;
  logic [1:0]                 wcnt_q, wcnt_d;
  logic [CFG_BITS-1:0]        shadow_q, shadow_d;
  logic                       err_q, err_d;
  logic [NUM_PORTS*SEL_W-1:0] sel_q, sel_d;
  logic [NUM_PORTS-1:0]       ovl_q, ovl_d;
  logic [NUM_PORTS-1:0]       regm_q, regm_d;

  // Next-state: frame assembly, error detection and commit.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    shadow_d = shadow_q;
    err_d    = 1'b0;
    sel_d    = sel_q;
    ovl_d    = ovl_q;
    regm_d   = regm_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          shadow_d[WORD_W-1:0] = cfg_data;
          if (cfg_last) begin
            // One-word frame: error on its own last word, nothing to drain.
            err_d = 1'b1;
          end else begin
            wcnt_d  = 2'd1;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (cfg_valid) begin
          if (wcnt_q != LAST_WORD) begin
            if (cfg_last) begin
              err_d   = 1'b1;
              wcnt_d  = '0;
              state_d = IDLE;
            end else begin
              shadow_d[2*WORD_W-1:WORD_W] = cfg_data;
              wcnt_d = wcnt_q + 2'd1;
            end
          end else if (cfg_last) begin
            // Bits above CFG_BITS in the final word are reserved and dropped.
            shadow_d[CFG_BITS-1:2*WORD_W] = cfg_data[TAIL_W-1:0];
            wcnt_d  = '0;
            state_d = FULL;
          end else begin
            err_d   = 1'b1;
            wcnt_d  = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (cfg_valid && cfg_last) begin
          state_d = IDLE;
        end
      end
      FULL: begin
        if (commit) begin
          sel_d   = shadow_q[OVL_BASE-1:0];
          ovl_d   = shadow_q[REG_BASE-1:OVL_BASE];
          regm_d  = shadow_q[CFG_BITS-1:REG_BASE];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and active configuration registers; reset selects drive zero (4'hF).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      shadow_q <= '0;
      err_q    <= 1'b0;
      sel_q    <= '1;
      ovl_q    <= '0;
      regm_q   <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
      sel_q    <= sel_d;
      ovl_q    <= ovl_d;
      regm_q   <= regm_d;
    end
  end

  // Handshake and status decoded from the registered state only.
  always_comb begin
    cfg_ready         = (state_q != FULL);
    cfg_loaded        = (state_q == FULL);
    cfg_err           = err_q;
    sel_o             = sel_q;
    overload_en_o     = ovl_q;
    registered_mode_o = regm_q;
  end

endmodule

// File: tb/tb_dice_router_cfg_loader.sv
// Self-checking bench for dice_router_cfg_loader: vector table, directed
// corner sequences and random traffic against a frame-level model.
module tb_dice_router_cfg_loader;
  import dice_router_cfg_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_last = 1'b0;
  logic        commit = 1'b0;
  logic [31:0] cfg_data = '0;
  logic        cfg_ready, cfg_loaded, cfg_err;
  logic [47:0] sel_o;
  logic [11:0] overload_en_o, registered_mode_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dice_router_cfg_loader dut (
    .clk               (clk),
    .rst               (rst),
    .cfg_valid         (cfg_valid),
    .cfg_ready         (cfg_ready),
    .cfg_data          (cfg_data),
    .cfg_last          (cfg_last),
    .commit            (commit),
    .cfg_loaded        (cfg_loaded),
    .cfg_err           (cfg_err),
    .sel_o             (sel_o),
    .overload_en_o     (overload_en_o),
    .registered_mode_o (registered_mode_o)
  );

  localparam logic [47:0] RST_SEL = 48'hFFFF_FFFF_FFFF;
  localparam logic [31:0] W0 = 32'h7654_3210;
  localparam logic [31:0] W1 = 32'hF801_9BA8;
  localparam logic [31:0] W2 = 32'hDEAD_00FF;
  localparam logic [47:0] NEW_SEL = 48'h9BA8_7654_3210;

  // Frame-level reference model: collected words, drain flag, full flag.
  logic [31:0] m_words[$];
  bit          m_drain, m_full, m_err;
  logic [47:0] m_sel;
  logic [11:0] m_ovl, m_reg;

  task automatic model_reset();
    m_words.delete();
    m_drain = 0;
    m_full  = 0;
    m_err   = 0;
    m_sel   = RST_SEL;
    m_ovl   = '0;
    m_reg   = '0;
  endtask

  task automatic model_edge(input bit v, input logic [31:0] d, input bit l, input bit c);
    logic [95:0] fr;
    m_err = 0;
    if (m_full) begin
      if (c) begin
        fr = {m_words[2], m_words[1], m_words[0]};
        m_sel  = fr[47:0];
        m_ovl  = fr[59:48];
        m_reg  = fr[71:60];
        m_full = 0;
        m_words.delete();
      end
    end else if (v) begin
      if (m_drain) begin
        if (l) m_drain = 0;
      end else begin
        m_words.push_back(d);
        if (l && m_words.size() == 3) begin
          m_full = 1;
        end else if (l) begin
          m_err = 1;
          m_words.delete();
        end else if (m_words.size() == 3) begin
          m_err   = 1;
          m_drain = 1;
          m_words.delete();
        end
      end
    end
  endtask

  function automatic logic [74:0] model_exp();
    return {~m_full, m_full, m_err, m_sel, m_ovl, m_reg};
  endfunction

  task automatic check(input string name, input logic [74:0] exp);
    logic [74:0] act;
    act = {cfg_ready, cfg_loaded, cfg_err, sel_o, overload_en_o, registered_mode_o};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got rdy/ld/err/sel/ovl/reg=%h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input bit l, input bit c);
    @(negedge clk);
    cfg_valid = v;
    cfg_data  = d;
    cfg_last  = l;
    commit    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string name, input bit v, input logic [31:0] d, input bit l,
                      input bit c);
    drive(v, d, l, c);
    model_edge(v, d, l, c);
    check(name, model_exp());
  endtask

  task automatic async_reset();
    @(negedge clk);
    cfg_valid = 0;
    cfg_last  = 0;
    commit    = 0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_reset", model_exp());
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        l;
    logic        c;
    logic [2:0]  flags;  // {ready, loaded, err}
    logic [47:0] sel;
    logic [11:0] ovl;
    logic [11:0] rgm;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b1, W0, 1'b0, 1'b0, 3'b100, RST_SEL, 12'h000, 12'h000};
    tbl[1] = '{1'b1, W1, 1'b0, 1'b1, 3'b100, RST_SEL, 12'h000, 12'h000};
    tbl[2] = '{1'b1, W2, 1'b1, 1'b0, 3'b010, RST_SEL, 12'h000, 12'h000};
    tbl[3] = '{1'b1, 32'h1234, 1'b0, 1'b0, 3'b010, RST_SEL, 12'h000, 12'h000};
    tbl[4] = '{1'b1, 32'h1234, 1'b1, 1'b0, 3'b010, RST_SEL, 12'h000, 12'h000};
    tbl[5] = '{1'b0, 32'h0, 1'b0, 1'b1, 3'b100, NEW_SEL, 12'h801, 12'hFFF};
    tbl[6] = '{1'b1, W0, 1'b1, 1'b0, 3'b101, NEW_SEL, 12'h801, 12'hFFF};
    tbl[7] = '{1'b0, 32'h0, 1'b0, 1'b0, 3'b100, NEW_SEL, 12'h801, 12'hFFF};

    model_reset();
    @(negedge clk);
    check("reset_state", {3'b100, RST_SEL, 12'h000, 12'h000});
    rst = 1'b0;
    step("idle", 0, 32'h0, 0, 0);
    step("idle_commit_ignored", 0, 32'h0, 0, 1);

    // Good frame, held valid in FULL, commit, back-to-back error word.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].c);
      model_edge(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].c);
      check($sformatf("vec%0d", i), {tbl[i].flags, tbl[i].sel, tbl[i].ovl, tbl[i].rgm});
    end

    // Last on word 1: error, back to idle, active config untouched.
    step("short_w0", 1, 32'hAAAA_5555, 0, 0);
    step("short_w1_err", 1, 32'h1111_2222, 1, 0);
    step("short_after", 0, 32'h0, 0, 1);
    step("short_idle", 1, 32'h0, 0, 0);
    step("short_again", 1, 32'h0, 1, 0);

    // Four words, last only on the fourth: error after word 2, word 3 drained.
    step("long_w0", 1, 32'h0101_0101, 0, 0);
    step("long_w1", 1, 32'h0202_0202, 0, 0);
    step("long_w2_err", 1, 32'h0303_0303, 0, 0);
    step("long_gap", 0, 32'h0, 0, 1);
    step("long_w3_drain", 1, 32'h0404_0404, 1, 0);
    step("ok_w0", 1, 32'h1357_9BDF, 0, 0);
    step("ok_w1", 1, 32'h5A5A_2468, 0, 0);
    step("ok_gap", 0, 32'h0, 0, 0);
    step("ok_w2", 1, 32'h0000_00C3, 1, 0);
    step("ok_commit", 0, 32'h0, 0, 1);

    // Reset between word 1 and word 2, then a clean frame.
    step("rst_w0", 1, 32'hCAFE_F00D, 0, 0);
    step("rst_w1", 1, 32'hBEEF_0000, 0, 0);
    async_reset();
    step("post_rst_w0", 1, 32'h8765_4321, 0, 0);
    step("post_rst_w1", 1, 32'h3C00_A987, 0, 0);
    step("post_rst_w2", 1, 32'h0000_0042, 1, 0);
    step("post_rst_commit", 1, 32'h0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0));
    end
    async_reset();
    step("final_idle", 0, 32'h0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
